usb_rx_byte_assembler: RTL and testbench

Receive-path stage directly upstream of the packet FSM. It takes the serial bit stream after NRZI decode and bit-unstuffing and hunts for SYNC. It assembles LSB-first bytes, checks the PID, and produces the per-byte strobes and flags the FSM consumes (byte_valid, is_sync, pid, pid_valid, last_data_byte). For DATA0/DATA1 packets it holds bytes in a 3-deep look-ahead buffer so the last payload byte can be tagged before the two CRC16 bytes.

---
 rtl/usb_rx_byte_assembler_pkg.sv | 42 ++++
 rtl/usb_rx_byte_assembler_if.sv | 34 +++
 rtl/usb_rx_byte_assembler_hold.sv | 60 ++++++
 rtl/usb_rx_byte_assembler.sv | 226 ++++++++++++++++++++++
 tb/tb_usb_rx_byte_assembler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_byte_assembler_pkg.sv
// Shared types and constants for the USB receive byte assembler.
// Covers PID encodings, the receive state enum and the PID integrity helpers.
package usb_rx_byte_assembler_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT     = 8'h80;
  localparam int         MAX_PKT_BYTES_DEFAULT = 1027;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ST_HUNT      = 3'd0,
    ST_PID       = 3'd1,
    ST_PASS_BODY = 3'd2,
    ST_DATA_BODY = 3'd3,
    ST_FLUSH     = 3'd4,
    ST_DISCARD   = 3'd5
  } rx_state_t;

  // Upper nibble of a PID byte carries the one's complement of the lower nibble.
  function automatic logic pid_check(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

  function automatic logic pid_is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  function automatic logic pid_is_defined(input logic [3:0] p);
    return (p == PID_OUT)   || (p == PID_IN)    || (p == PID_SOF)   ||
           (p == PID_SETUP) || (p == PID_DATA0) || (p == PID_DATA1) ||
           (p == PID_ACK)   || (p == PID_NAK)   || (p == PID_STALL);
  endfunction

endpackage

// File: rtl/usb_rx_byte_assembler_if.sv
// Bit-stream input and byte/flag output bundle of the USB receive byte assembler.
// Inputs: bit_valid qualifies bit_in for one clk, no backpressure; eop_in is a one-clk pulse.
// Outputs: byte_valid is a one-clk strobe qualifying byte_data and the per-byte flags.
interface usb_rx_byte_assembler_if;
  import usb_rx_byte_assembler_pkg::*;

  logic       bit_valid;
  logic       bit_in;
  logic       eop_in;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       is_sync;
  logic [3:0] pid;
  logic       pid_valid;
  logic       last_data_byte;
  logic       eop_strobe;
  logic       pid_err;
  logic       rx_error;
  rx_state_t  dbg_state;

  modport master (
    output bit_valid, bit_in, eop_in,
    input  byte_valid, byte_data, is_sync, pid, pid_valid, last_data_byte,
    input  eop_strobe, pid_err, rx_error, dbg_state
  );

  modport slave (
    input  bit_valid, bit_in, eop_in,
    output byte_valid, byte_data, is_sync, pid, pid_valid, last_data_byte,
    output eop_strobe, pid_err, rx_error, dbg_state
  );

endinterface

// File: rtl/usb_rx_byte_assembler_hold.sv
// Three-entry look-ahead FIFO holding data-packet bytes until the packet end is known.
// Entry 0 is always the oldest byte; push and pop may occur in the same cycle.
module usb_rx_byte_assembler_hold (
  input  logic       clk,
  input  logic       nRST,
  input  logic       i_clear,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_head,
  output logic [1:0] o_count
);

  logic [7:0] r_e0, r_e1, r_e2;
  logic [1:0] r_count;
  logic [7:0] w_e0, w_e1, w_e2;
  logic [1:0] w_wr_idx;
  logic [1:0] w_count_nxt;

  // A simultaneous pop frees the head, so the write slot moves down by one.
  assign w_wr_idx    = i_pop ? (r_count - 2'd1) : r_count;
  assign w_count_nxt = r_count + {1'b0, i_push} - {1'b0, i_pop};

  always_comb begin
    w_e0 = r_e0;
    w_e1 = r_e1;
    w_e2 = r_e2;
    if (i_pop) begin
      w_e0 = r_e1;
      w_e1 = r_e2;
    end
    if (i_push) begin
      case (w_wr_idx)
        2'd0:    w_e0 = i_data;
        2'd1:    w_e1 = i_data;
        default: w_e2 = i_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_e2    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_e0    <= w_e0;
      r_e1    <= w_e1;
      r_e2    <= w_e2;
      r_count <= w_count_nxt;
    end
  end

  assign o_head  = r_e0;
  assign o_count = r_count;

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// USB receive byte assembler: SYNC hunt, LSB-first byte assembly, PID check, and
// data-packet look-ahead so the last payload byte is tagged ahead of the CRC16 bytes.
module usb_rx_byte_assembler
  import usb_rx_byte_assembler_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         MAX_PKT_BYTES = MAX_PKT_BYTES_DEFAULT
) (
  input logic                    clk,
  input logic                    nRST,
  usb_rx_byte_assembler_if.slave rx_if
);

  localparam logic [10:0] LP_OVF_AT = 11'(MAX_PKT_BYTES - 1);

  rx_state_t   r_state, w_state_nxt;
  logic [6:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [10:0] r_byte_cnt;
  logic        r_flush_err;

  logic        r_byte_valid, r_is_sync, r_last, r_eop, r_pid_err, r_rx_error, r_pid_valid;
  logic [7:0]  r_byte_data;
  logic [3:0]  r_pid;

  logic        w_bit_acc, w_byte_done, w_sync_hit, w_ovf, w_pid_ok;
  logic [7:0]  w_window;
  logic [7:0]  w_hold_head;
  logic [1:0]  w_hold_count;

  logic        w_bv, w_sync, w_last, w_eop, w_perr, w_rxerr;
  logic [7:0]  w_bd;
  logic        w_pid_set, w_pid_clr, w_push, w_pop, w_clear, w_ferr_set, w_ferr_clr;

  // Bits are taken only in states that assemble; eop_in wins over a same-cycle bit.
  assign w_bit_acc   = rx_if.bit_valid && !rx_if.eop_in &&
                       (r_state inside {ST_HUNT, ST_PID, ST_PASS_BODY, ST_DATA_BODY});
  assign w_window    = {rx_if.bit_in, r_shift};
  assign w_sync_hit  = w_bit_acc && (r_state == ST_HUNT) && (w_window == SYNC_BYTE);
  assign w_byte_done = w_bit_acc && (r_state != ST_HUNT) && (r_bit_cnt == 3'd7);
  assign w_ovf       = (r_byte_cnt == LP_OVF_AT);
  assign w_pid_ok    = pid_check(w_window);

  usb_rx_byte_assembler_hold u_hold (
    .clk     (clk),
    .nRST    (nRST),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_window),
    .o_head  (w_hold_head),
    .o_count (w_hold_count)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= ST_HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT: if (w_sync_hit) w_state_nxt = ST_PID;
      ST_PID: begin
        if (rx_if.eop_in)     w_state_nxt = ST_HUNT;
        else if (w_byte_done) w_state_nxt = !w_pid_ok ? ST_DISCARD :
                                            pid_is_data(w_window[3:0]) ? ST_DATA_BODY : ST_PASS_BODY;
      end
      ST_PASS_BODY: begin
        if (rx_if.eop_in)              w_state_nxt = ST_HUNT;
        else if (w_byte_done && w_ovf) w_state_nxt = ST_DISCARD;
      end
      ST_DATA_BODY: begin
        if (rx_if.eop_in)              w_state_nxt = (r_bit_cnt != 3'd0) ? ST_HUNT : ST_FLUSH;
        else if (w_byte_done && w_ovf) w_state_nxt = ST_DISCARD;
      end
      ST_FLUSH:   if (!r_flush_err && (w_hold_count == 2'd0)) w_state_nxt = ST_HUNT;
      ST_DISCARD: if (rx_if.eop_in) w_state_nxt = ST_HUNT;
      default:    w_state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    w_bv       = 1'b0;
    w_bd       = '0;
    w_sync     = 1'b0;
    w_last     = 1'b0;
    w_eop      = 1'b0;
    w_perr     = 1'b0;
    w_rxerr    = 1'b0;
    w_pid_set  = 1'b0;
    w_pid_clr  = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_clear    = 1'b0;
    w_ferr_set = 1'b0;
    w_ferr_clr = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_sync_hit) begin
          w_bv      = 1'b1;
          w_bd      = SYNC_BYTE;
          w_sync    = 1'b1;
          w_pid_clr = 1'b1;
        end
      end
      ST_PID: begin
        if (!rx_if.eop_in && w_byte_done) begin
          w_bv      = 1'b1;
          w_bd      = w_window;
          w_pid_set = w_pid_ok;
          w_perr    = !w_pid_ok;
        end
      end
      ST_PASS_BODY: begin
        if (rx_if.eop_in) begin
          w_bv    = 1'b1;
          w_eop   = 1'b1;
          w_rxerr = (r_bit_cnt != 3'd0);
        end else if (w_byte_done) begin
          if (w_ovf) begin
            w_rxerr = 1'b1;
          end else begin
            w_bv = 1'b1;
            w_bd = w_window;
          end
        end
      end
      ST_DATA_BODY: begin
        if (rx_if.eop_in) begin
          if (r_bit_cnt != 3'd0) begin
            w_bv    = 1'b1;
            w_eop   = 1'b1;
            w_rxerr = 1'b1;
            w_clear = 1'b1;
          end else if (w_hold_count < 2'd2) begin
            w_clear    = 1'b1;
            w_ferr_set = 1'b1;
          end
        end else if (w_byte_done) begin
          if (w_ovf) begin
            w_rxerr = 1'b1;
            w_clear = 1'b1;
          end else begin
            w_push = 1'b1;
            if (w_hold_count == 2'd3) begin
              w_pop = 1'b1;
              w_bv  = 1'b1;
              w_bd  = w_hold_head;
            end
          end
        end
      end
      ST_FLUSH: begin
        // Three held bytes at this point means payload + CRC lo + CRC hi remain.
        if (r_flush_err) begin
          w_rxerr    = 1'b1;
          w_ferr_clr = 1'b1;
        end else if (w_hold_count != 2'd0) begin
          w_bv   = 1'b1;
          w_bd   = w_hold_head;
          w_pop  = 1'b1;
          w_last = (w_hold_count == 2'd3);
        end else begin
          w_bv  = 1'b1;
          w_eop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_is_sync    <= 1'b0;
      r_last       <= 1'b0;
      r_eop        <= 1'b0;
      r_pid_err    <= 1'b0;
      r_rx_error   <= 1'b0;
      r_pid_valid  <= 1'b0;
      r_pid        <= '0;
      r_shift      <= 7'h7F;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_flush_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_bv;
      r_byte_data  <= w_bd;
      r_is_sync    <= w_sync;
      r_last       <= w_last;
      r_eop        <= w_eop;
      r_pid_err    <= w_perr;
      r_rx_error   <= w_rxerr;
      if (w_pid_clr) begin
        r_pid_valid <= 1'b0;
        r_pid       <= '0;
      end else if (w_pid_set) begin
        r_pid_valid <= 1'b1;
        r_pid       <= w_window[3:0];
      end
      // Ones in the window cannot form SYNC, so the hunt restarts from a clean slate.
      if ((r_state != ST_HUNT) && (w_state_nxt == ST_HUNT)) r_shift <= 7'h7F;
      else if (w_bit_acc)                                   r_shift <= w_window[7:1];
      if (r_state == ST_HUNT) r_bit_cnt <= '0;
      else if (w_bit_acc)     r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_state == ST_PID)  r_byte_cnt <= '0;
      else if (w_byte_done)   r_byte_cnt <= r_byte_cnt + 11'd1;
      if (w_ferr_set)         r_flush_err <= 1'b1;
      else if (w_ferr_clr)    r_flush_err <= 1'b0;
    end
  end

  assign rx_if.byte_valid     = r_byte_valid;
  assign rx_if.byte_data      = r_byte_data;
  assign rx_if.is_sync        = r_is_sync;
  assign rx_if.pid            = r_pid;
  assign rx_if.pid_valid      = r_pid_valid;
  assign rx_if.last_data_byte = r_last;
  assign rx_if.eop_strobe     = r_eop;
  assign rx_if.pid_err        = r_pid_err;
  assign rx_if.rx_error       = r_rx_error;
  assign rx_if.dbg_state      = r_state;

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Self-checking bench for usb_rx_byte_assembler: directed packets plus randomized
// packets, each predicted by a packet-level model and compared event by event.
module tb_usb_rx_byte_assembler;
  import usb_rx_byte_assembler_pkg::*;

  localparam int W    = 19;
  localparam int MAXB = 1027;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  usb_rx_byte_assembler_if rx_if ();

  usb_rx_byte_assembler #(.SYNC_BYTE(8'h80), .MAX_PKT_BYTES(MAXB)) dut (
    .clk   (clk),
    .nRST  (nRST),
    .rx_if (rx_if)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_cyc[$];
  logic [7:0]   body_q[$];
  int           cyc   = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  always @(posedge clk) cyc++;

  // Event word: {pid_err, rx_error, byte_valid, is_sync, last, eop, pid_valid, pid, data}
  function automatic logic [W-1:0] ev(input logic pe, re, v, s, l, e, pv,
                                      input logic [3:0] p, input logic [7:0] d);
    return {pe, re, v, s, l, e, pv, p, d};
  endfunction

  function automatic logic [W-1:0] raw_word();
    return {rx_if.pid_err, rx_if.rx_error, rx_if.byte_valid, rx_if.is_sync,
            rx_if.last_data_byte, rx_if.eop_strobe, rx_if.pid_valid, rx_if.pid, rx_if.byte_data};
  endfunction

  always @(negedge clk) begin
    if (nRST && (rx_if.byte_valid || rx_if.pid_err || rx_if.rx_error)) begin
      obs_q.push_back(ev(rx_if.pid_err, rx_if.rx_error, rx_if.byte_valid, rx_if.is_sync,
                         rx_if.last_data_byte, rx_if.eop_strobe, rx_if.pid_valid,
                         rx_if.pid_valid ? rx_if.pid : 4'h0,
                         rx_if.byte_valid ? rx_if.byte_data : 8'h00));
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_if.bit_valid = 1'b1;
    rx_if.bit_in    = b;
    @(posedge clk);
    #1;
    rx_if.bit_valid = 1'b0;
    rx_if.bit_in    = 1'b0;
    if ($urandom_range(0, 3) == 0) idle(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_eop();
    rx_if.eop_in = 1'b1;
    @(posedge clk);
    #1;
    rx_if.eop_in = 1'b0;
    idle(8);
  endtask

  // Garbage never holds seven zeros in a row, so it cannot look like SYNC.
  task automatic send_packet(input logic [7:0] pid_byte, input int part_bits, input int garbage);
    for (int g = 0; g < garbage; g++) send_bit((g % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
    send_byte(8'h80);
    send_byte(pid_byte);
    foreach (body_q[i]) send_byte(body_q[i]);
    for (int b = 0; b < part_bits; b++) send_bit(1'($urandom_range(0, 1)));
    send_eop();
  endtask

  // Packet-level prediction: data packets keep their final three bytes (last payload,
  // CRC lo, CRC hi) back until the end is known; everything else streams through.
  task automatic model_packet(input logic [7:0] pid_byte, input int part_bits);
    logic [3:0] p;
    bit         ok, is_data;
    int         n, ne;
    p       = pid_byte[3:0];
    ok      = (pid_byte[7:4] == ~pid_byte[3:0]);
    is_data = ok && (p == 4'h3 || p == 4'hB);
    n       = body_q.size();
    exp_q.push_back(ev(0, 0, 1, 1, 0, 0, 0, 4'h0, 8'h80));
    if (!ok) begin
      exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 4'h0, pid_byte));
      return;
    end
    exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 1, p, pid_byte));
    if (n >= MAXB) begin
      ne = is_data ? ((MAXB - 1 > 3) ? MAXB - 4 : 0) : MAXB - 1;
      for (int i = 0; i < ne; i++) exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 1, p, body_q[i]));
      exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 1, p, 8'h00));
      return;
    end
    if (part_bits != 0) begin
      ne = is_data ? ((n > 3) ? n - 3 : 0) : n;
      for (int i = 0; i < ne; i++) exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 1, p, body_q[i]));
      exp_q.push_back(ev(0, 1, 1, 0, 0, 1, 1, p, 8'h00));
      return;
    end
    if (is_data && n < 2) begin
      exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 1, p, 8'h00));
    end else begin
      for (int i = 0; i < n; i++)
        exp_q.push_back(ev(0, 0, 1, 0, is_data && n >= 3 && i == n - 3, 0, 1, p, body_q[i]));
    end
    exp_q.push_back(ev(0, 0, 1, 0, 0, 1, 1, p, 8'h00));
  endtask

  task automatic check_packet(input string tag, input bit consec);
    int m;
    check_int({tag, ".count"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check_word($sformatf("%s.ev%0d", tag, i), obs_q[i], exp_q[i]);
    if (consec && obs_cyc.size() >= 4)
      check_int({tag, ".flush_consec"}, obs_cyc[obs_cyc.size()-1] - obs_cyc[obs_cyc.size()-4], 3);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic run_packet(input string tag, input logic [7:0] pid_byte,
                            input int part_bits, input int garbage, input bit consec);
    model_packet(pid_byte, part_bits);
    send_packet(pid_byte, part_bits, garbage);
    check_packet(tag, consec);
  endtask

  initial begin
    logic [3:0] pass_pids[7];
    logic [3:0] p;
    logic [7:0] pb;
    int         kind, len, part;
    pass_pids = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h2, 4'hA, 4'hE};
    rx_if.bit_valid = 1'b0;
    rx_if.bit_in    = 1'b0;
    rx_if.eop_in    = 1'b0;

    // Reset state and quiet release
    #3;
    check_word("reset.outputs", raw_word(), '0);
    check_int("reset.state", int'(rx_if.dbg_state), int'(ST_HUNT));
    idle(3);
    nRST = 1'b1;
    idle(6);
    check_int("reset.release_quiet", obs_q.size(), 0);

    // SETUP token-like packet passes bytes straight through
    body_q = '{8'h15, 8'hA0};
    run_packet("setup", 8'h2D, 0, 5, 1'b0);

    // DATA0 with payload: last payload byte tagged, then CRC bytes and eop back to back
    body_q = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22};
    run_packet("data0", 8'hC3, 0, 3, 1'b1);

    // Reset asserted mid DATA_BODY
    body_q.delete();
    exp_q.push_back(ev(0, 0, 1, 1, 0, 0, 0, 4'h0, 8'h80));
    exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 1, 4'h3, 8'hC3));
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    #2;
    nRST = 1'b0;
    #1;
    check_word("rst_mid.outputs", raw_word(), '0);
    idle(3);
    nRST = 1'b1;
    idle(10);
    check_packet("rst_mid", 1'b0);

    // DATA1 zero-length payload
    body_q = '{8'h00, 8'h00};
    run_packet("data1_zlp", 8'h4B, 0, 0, 1'b0);

    // Bad PID: discarded bytes include a SYNC-valued byte
    body_q = '{8'hDE, 8'h80, 8'h01};
    run_packet("bad_pid", 8'h2C, 0, 2, 1'b0);

    // Partial byte at EOP in a data packet
    body_q = '{8'hAA};
    run_packet("partial", 8'hC3, 5, 0, 1'b0);

    // Data packet ending with fewer than two bytes held
    body_q = '{8'h5A};
    run_packet("data_short", 8'hC3, 0, 1, 1'b0);

    // Randomized packets
    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(0, 6);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      if (kind == 0) begin
        p  = pass_pids[$urandom_range(0, 6)];
        pb = {~p, p};
      end else if (kind == 1) begin
        p  = ($urandom_range(0, 1) == 1) ? 4'hB : 4'h3;
        pb = {~p, p};
      end else begin
        pb = 8'($urandom_range(0, 255));
        if (pb[7:4] == ~pb[3:0]) pb[0] = ~pb[0];
      end
      body_q.delete();
      for (int i = 0; i < len; i++) body_q.push_back(8'($urandom_range(0, 255)));
      run_packet($sformatf("rand%0d", k), pb, part, $urandom_range(0, 12), 1'b0);
    end

    // Overflow on a long token-class packet
    body_q.delete();
    for (int i = 0; i < MAXB; i++) body_q.push_back(8'($urandom_range(0, 255)));
    run_packet("overflow", 8'hE1, 0, 0, 1'b0);

    // Recovery after overflow
    body_q = '{8'h42};
    run_packet("after_ovf", 8'h69, 0, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
